mips_cpu_hilo_div_ctrl: RTL and testbench

Sequencer that owns the HI/LO register pair and drives the unsigned iterative divider (mips_cpu_divider) for DIV/DIVU instructions. Accepts one operation at a time from the execute stage and converts signed operands to magnitudes. Waits for the divider's done signal, applies the MIPS sign fix-up and commits remainder to HI and quotient to LO. Also executes MTHI/MTLO and raises busy so the pipeline stalls while a divide is in flight.

---
 rtl/mips_cpu_hilo_div_ctrl_if.sv | 39 +++
 rtl/mips_cpu_hilo_div_ctrl.sv | 138 +++++++++++++
 tb/tb_mips_cpu_hilo_div_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_hilo_div_ctrl_if.sv
// Bundle between the execute stage, the HI/LO divide sequencer and the
// unsigned iterative divider. The sequencer takes the slave view; whatever
// drives ops and models the divider takes the master view.
interface mips_cpu_hilo_div_ctrl_if;
  // Execute-stage request
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  // Status and architectural state
  logic        op_ready;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;
  logic        timeout;
  // Divider side
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_done;
  logic        div_dbz;

  modport slave (
    input  op_valid, op_code, op_a, op_b,
           div_quotient, div_remainder, div_done, div_dbz,
    output op_ready, busy, hi, lo, dbz, timeout,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output op_valid, op_code, op_a, op_b,
           div_quotient, div_remainder, div_done, div_dbz,
    input  op_ready, busy, hi, lo, dbz, timeout,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/mips_cpu_hilo_div_ctrl.sv
// HI/LO owner and divide sequencer: executes MTHI/MTLO in one cycle,
// runs DIV/DIVU through an unsigned divider with sign fix-up, and flags
// divide-by-zero and divider timeouts with one-cycle pulses.
module mips_cpu_hilo_div_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input logic                     clk,
  input logic                     reset,
  mips_cpu_hilo_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIX} state_t;

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_hi, r_lo;
  logic [31:0]       r_dividend, r_divisor;
  logic [31:0]       r_q, r_r;
  logic              r_neg_q, r_neg_r;
  logic              r_dbz, r_timeout;

  logic              w_accept;
  logic              w_is_div;
  logic              w_signed;
  logic              w_b_zero;
  logic              w_cnt_last;
  logic [31:0]       w_abs_a, w_abs_b;

  assign w_accept   = (r_state == S_IDLE) && bus.op_valid;
  assign w_is_div   = (bus.op_code == OP_DIVU) || (bus.op_code == OP_DIV);
  assign w_signed   = (bus.op_code == OP_DIV);
  assign w_b_zero   = (bus.op_b == 32'd0);
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // |INT_MIN| wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign w_abs_a    = bus.op_a[31] ? -bus.op_a : bus.op_a;
  assign w_abs_b    = bus.op_b[31] ? -bus.op_b : bus.op_b;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; a divider dbz or a timeout both return straight to IDLE
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_div && !w_b_zero) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.div_done)    w_next = bus.div_dbz ? S_IDLE : S_FIX;
        else if (w_cnt_last) w_next = S_IDLE;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: HI/LO commits, operand latching, WAIT counter and status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= '0;
      r_dbz      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_dbz     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.op_code)
              OP_MTHI: r_hi <= bus.op_a;
              OP_MTLO: r_lo <= bus.op_a;
              default: begin
                if (w_b_zero) begin
                  r_dbz <= 1'b1;
                end else begin
                  r_dividend <= w_signed ? w_abs_a : bus.op_a;
                  r_divisor  <= w_signed ? w_abs_b : bus.op_b;
                  r_neg_q    <= w_signed && (bus.op_a[31] ^ bus.op_b[31]);
                  r_neg_r    <= w_signed && bus.op_a[31];
                end
              end
            endcase
          end
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.div_done) begin
            if (bus.div_dbz) begin
              r_dbz <= 1'b1;
            end else begin
              r_q <= bus.div_quotient;
              r_r <= bus.div_remainder;
            end
          end else if (w_cnt_last) begin
            r_timeout <= 1'b1;
          end
        end
        S_FIX: begin
          // Remainder takes the dividend's sign, quotient the xor of both signs.
          r_lo <= r_neg_q ? -r_q : r_q;
          r_hi <= r_neg_r ? -r_r : r_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready     = (r_state == S_IDLE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;
  assign bus.dbz          = r_dbz;
  assign bus.timeout      = r_timeout;
  assign bus.div_start    = (r_state == S_START);
  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = r_divisor;

endmodule

// File: tb/tb_mips_cpu_hilo_div_ctrl.sv
// Self-checking bench for the HI/LO divide sequencer with a behavioural
// divider model of programmable latency.
module tb_mips_cpu_hilo_div_ctrl;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_hilo_div_ctrl_if bus ();

  mips_cpu_hilo_div_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  // Divider model controls
  int   mdl_latency = 1;
  bit   mdl_never   = 1'b0;
  bit   mdl_dbz     = 1'b0;
  int   pend        = 0;
  logic [31:0] cap_n, cap_d;

  // Divider model: answers an unsigned divide mdl_latency cycles after start
  initial begin
    bus.div_done      = 1'b0;
    bus.div_dbz       = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    forever begin
      @(negedge clk);
      bus.div_done = 1'b0;
      bus.div_dbz  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.div_done      = 1'b1;
          bus.div_dbz       = mdl_dbz;
          bus.div_quotient  = (cap_d == 0) ? 32'hFFFF_FFFF : cap_n / cap_d;
          bus.div_remainder = (cap_d == 0) ? cap_n : cap_n % cap_d;
        end
      end else if (bus.div_start === 1'b1 && !mdl_never) begin
        pend  = mdl_latency;
        cap_n = bus.div_dividend;
        cap_d = bus.div_divisor;
      end
    end
  end

  // Reference: architectural MIPS divide via wide signed arithmetic
  function automatic void ref_div(input logic [1:0] code, input logic [31:0] a, b,
                                  output logic [31:0] q, r);
    longint sa, sb;
    if (code == 2'b00) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.op_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.div_start !== 1'b0 || bus.dbz !== 1'b0 || bus.timeout !== 1'b0 ||
        bus.div_dividend !== 32'd0 || bus.div_divisor !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h rdy=%b busy=%b start=%b dbz=%b tmo=%b dvd=%h dvs=%h, required zeros with rdy=1",
               bus.hi, bus.lo, bus.op_ready, bus.busy, bus.div_start, bus.dbz, bus.timeout,
               bus.div_dividend, bus.div_divisor);
    end
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  // Single MTHI/MTLO with a one-cycle valid
  task automatic mt(input logic [1:0] code, input logic [31:0] data);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_a = data; bus.op_b = $urandom;
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (code == 2'b10) exp_hi = data; else exp_lo = data;
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL mt: hi=%h lo=%h rdy=%b, required hi=%h lo=%h rdy=1",
               bus.hi, bus.lo, bus.op_ready, exp_hi, exp_lo);
    end
  endtask

  // Full divide through the divider model; ddbz makes the divider report dbz
  task automatic exec_div(input logic [1:0] code, input logic [31:0] a, b,
                          input int lat, input bit ddbz, input string name);
    logic [31:0] q, r, ea, eb;
    int n;
    bit seen_bad;
    mdl_latency = lat; mdl_dbz = ddbz; mdl_never = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    ea = (code == 2'b01 && a[31]) ? -a : a;
    eb = (code == 2'b01 && b[31]) ? -b : b;
    checks++;
    if (bus.div_start !== 1'b1 || bus.div_dividend !== ea || bus.div_divisor !== eb || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start: start=%b dvd=%h dvs=%h busy=%b, required start=1 dvd=%h dvs=%h busy=1",
               name, bus.div_start, bus.div_dividend, bus.div_divisor, bus.busy, ea, eb);
    end
    n = 0;
    seen_bad = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.op_ready === 1'b1) break;
      if (bus.div_start !== 1'b0 || bus.div_dividend !== ea || bus.div_divisor !== eb ||
          bus.hi !== exp_hi || bus.lo !== exp_lo) seen_bad = 1'b1;
    end
    checks++;
    if (seen_bad) begin
      errors++;
      $display("FAIL %s busy_phase: start pulse repeated, operands moved or hi/lo changed while busy", name);
    end
    checks++;
    if (n !== (ddbz ? lat + 1 : lat + 2)) begin
      errors++;
      $display("FAIL %s latency: ready after %0d cycles, required %0d", name, n, ddbz ? lat + 1 : lat + 2);
    end
    if (!ddbz) begin
      ref_div(code, a, b, q, r);
      exp_lo = q; exp_hi = r;
    end
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.dbz !== ddbz || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h dbz=%b tmo=%b, required hi=%h lo=%h dbz=%b tmo=0",
               name, bus.hi, bus.lo, bus.dbz, bus.timeout, exp_hi, exp_lo, ddbz);
    end
  endtask

  // Divide by zero rejected at accept
  task automatic exec_dbz(input logic [1:0] code, input logic [31:0] a);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_a = a; bus.op_b = '0;
    @(negedge clk);
    bus.op_valid = 1'b0;
    checks++;
    if (bus.dbz !== 1'b1 || bus.div_start !== 1'b0 || bus.op_ready !== 1'b1 ||
        bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      errors++;
      $display("FAIL dbz_pulse: dbz=%b start=%b rdy=%b hi=%h lo=%h, required dbz=1 start=0 rdy=1 hi=%h lo=%h",
               bus.dbz, bus.div_start, bus.op_ready, bus.hi, bus.lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    checks++;
    if (bus.dbz !== 1'b0 || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL dbz_width: dbz=%b start=%b one cycle later, required 0 0", bus.dbz, bus.div_start);
    end
  endtask

  task automatic test_mt_back_to_back();
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'b10; bus.op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    exp_hi = 32'hDEAD_BEEF;
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      errors++;
      $display("FAIL mthi_first: hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    bus.op_code = 2'b11; bus.op_a = 32'h1234_5678;
    @(posedge clk); #1;
    exp_lo = 32'h1234_5678;
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_second: hi=%h lo=%h rdy=%b, required hi=%h lo=%h rdy=1",
               bus.hi, bus.lo, bus.op_ready, exp_hi, exp_lo);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic test_directed_div();
    exec_div(2'b00, 32'd7, 32'd2, 3, 1'b0, "divu_7_2");
    exec_div(2'b01, 32'hFFFF_FFF9, 32'd2, 2, 1'b0, "div_m7_2");
    exec_div(2'b01, 32'd7, 32'hFFFF_FFFE, 1, 1'b0, "div_7_m2");
    exec_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4, 1'b0, "div_intmin_m1");
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      errors++;
      $display("FAIL intmin_abs: hi=%h lo=%h, required hi=00000000 lo=80000000", bus.hi, bus.lo);
    end
    exec_div(2'b00, 32'hFFFF_FFFF, 32'd10, TMO, 1'b0, "done_at_last_wait");
  endtask

  task automatic test_dbz();
    mt(2'b10, 32'h0000_00AA);
    mt(2'b11, 32'h0000_00BB);
    exec_dbz(2'b00, 32'd5);
    exec_dbz(2'b01, 32'hFFFF_FFF0);
    exec_div(2'b01, 32'd50, 32'd3, 3, 1'b1, "divider_dbz");
  endtask

  task automatic test_busy_hold();
    logic [31:0] q, r;
    int n;
    mdl_latency = 4; mdl_dbz = 1'b0; mdl_never = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'b01; bus.op_a = 32'd100; bus.op_b = 32'hFFFF_FFF9;
    @(negedge clk);
    bus.op_code = 2'b11; bus.op_a = 32'h5555_AAAA;
    n = 0;
    while (n < 40 && bus.op_ready !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    ref_div(2'b01, 32'd100, 32'hFFFF_FFF9, q, r);
    exp_lo = q; exp_hi = r;
    checks++;
    if (bus.op_ready !== 1'b1 || bus.lo !== exp_lo || bus.hi !== exp_hi) begin
      errors++;
      $display("FAIL hold_mtlo_blocked: rdy=%b hi=%h lo=%h, required rdy=1 hi=%h lo=%h",
               bus.op_ready, bus.hi, bus.lo, exp_hi, exp_lo);
    end
    @(posedge clk); #1;
    exp_lo = 32'h5555_AAAA;
    checks++;
    if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin
      errors++;
      $display("FAIL hold_mtlo_accept: hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    mdl_never = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.op_a = 32'd9; bus.op_b = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (bus.timeout === 1'b1) break;
    end
    checks++;
    if (n !== TMO + 1 || bus.op_ready !== 1'b1 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      errors++;
      $display("FAIL timeout_pulse: seen after %0d cycles rdy=%b hi=%h lo=%h, required %0d cycles rdy=1 hi=%h lo=%h",
               n, bus.op_ready, bus.hi, bus.lo, TMO + 1, exp_hi, exp_lo);
    end
    @(negedge clk);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: timeout=%b one cycle later, required 0", bus.timeout);
    end
    mdl_never = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    mdl_latency = 6; mdl_dbz = 1'b0; mdl_never = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'b01; bus.op_a = 32'd1000; bus.op_b = 32'd7;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait: hi=%h lo=%h rdy=%b, required 0 0 1", bus.hi, bus.lo, bus.op_ready);
    end
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.op_ready !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL late_done: late div_done disturbed block, hi=%h lo=%h rdy=%b, required 0 0 1",
               bus.hi, bus.lo, bus.op_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0]  code;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      code = 2'($urandom_range(0, 3));
      a    = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 5));
        2:       b = -32'($urandom_range(1, 5));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if (code[1])        mt(code, a);
      else if (b == 0)    exec_dbz(code, a);
      else                exec_div(code, a, b, int'($urandom_range(1, TMO)), 1'b0, "random_div");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mt_back_to_back();
    test_directed_div();
    test_dbz();
    test_busy_hold();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
